// File: rtl/act_pingpong_ram_pkg.sv
// Shared LSTM activation-memory constants and the read-pipeline stage type.
package act_pingpong_ram_pkg;

    localparam int unsigned ACT_WIDTH  = 32;
    localparam int unsigned N_UNITS    = 53;
    localparam int unsigned N_SLOTS    = 8;
    localparam int unsigned ACT_DEPTH  = N_UNITS * N_SLOTS;
    localparam int unsigned ACT_ADDR_W = 9;

    typedef struct packed {
        logic valid;
        logic bank;
        logic ok;
    } rd_stage_t;

endpackage

// File: rtl/act_pingpong_ram_sdp_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module sdp_bank #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 424,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/act_pingpong_ram.sv
// Ping-pong activation memory: one bank is written while the other is read,
// and a swap pulse exchanges them at a timestep boundary.
module act_pingpong_ram
    import act_pingpong_ram_pkg::*;
#(
    parameter int unsigned WIDTH  = ACT_WIDTH,
    parameter int unsigned DEPTH  = ACT_DEPTH,
    parameter int unsigned ADDR_W = ACT_ADDR_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_swap,
    output logic              o_wr_bank,
    output logic [ADDR_W:0]   o_wr_cnt,
    output logic              o_addr_err
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic             r_wr_bank;
    logic [ADDR_W:0]  r_wr_cnt;
    logic             r_addr_err;
    rd_stage_t        r_s1;

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_bank_q [2];
    logic [WIDTH-1:0] w_mux;

    assign w_wr_ok  = ({1'b0, i_wr_addr} < LP_DEPTH);
    assign w_rd_ok  = ({1'b0, i_rd_addr} < LP_DEPTH);
    // Writes in the reset cycle are dropped; the RAM itself keeps its contents.
    assign w_wr_acc = i_wr_en & w_wr_ok & ~i_rst;
    assign w_rd_acc = i_rd_en & w_rd_ok;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sdp_bank #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .i_clk   (i_clk),
            .i_we    (w_wr_acc & (r_wr_bank == 1'(b))),
            .i_waddr (i_wr_addr),
            .i_wdata (i_wr_data),
            .i_re    (w_rd_acc & (r_wr_bank != 1'(b))),
            .i_raddr (i_rd_addr),
            .o_rdata (w_bank_q[b])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_wr_bank  <= r_wr_bank ^ i_swap;
            r_addr_err <= r_addr_err | (i_wr_en & ~w_wr_ok) | (i_rd_en & ~w_rd_ok);
            if (i_swap) begin
                r_wr_cnt <= '0;
            end else if (w_wr_acc && (r_wr_cnt != LP_DEPTH)) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // Bank select and range flag only advance on a read, so the mux holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= i_rd_en;
            if (i_rd_en) begin
                r_s1.bank <= ~r_wr_bank;
                r_s1.ok   <= w_rd_ok;
            end
        end
    end

    assign w_mux = r_s1.ok ? w_bank_q[r_s1.bank] : '0;

    if (RD_LAT == 2) begin : g_lat2
        logic             r_rd_valid2;
        logic [WIDTH-1:0] r_rd_data2;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rd_valid2 <= 1'b0;
                r_rd_data2  <= '0;
            end else begin
                r_rd_valid2 <= r_s1.valid;
                if (r_s1.valid) begin
                    r_rd_data2 <= w_mux;
                end
            end
        end

        assign o_rd_valid = r_rd_valid2;
        assign o_rd_data  = r_rd_data2;
    end else begin : g_lat1
        assign o_rd_valid = r_s1.valid;
        assign o_rd_data  = w_mux;
    end

    assign o_wr_bank  = r_wr_bank;
    assign o_wr_cnt   = r_wr_cnt;
    assign o_addr_err = r_addr_err;

endmodule

// File: tb/tb_act_pingpong_ram.sv
// Bench for act_pingpong_ram: RD_LAT=1 and RD_LAT=2 instances share stimulus
// and are checked every cycle against an array-based reference model.
module tb_act_pingpong_ram;

    localparam int D = 424;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic        swap;

    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic        wr_bank1, wr_bank2;
    logic [9:0]  wr_cnt1, wr_cnt2;
    logic        addr_err1, addr_err2;

    always #5 clk = ~clk;

    act_pingpong_ram #(.WIDTH(32), .DEPTH(D), .ADDR_W(9), .RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
        .i_swap(swap), .o_wr_bank(wr_bank1), .o_wr_cnt(wr_cnt1), .o_addr_err(addr_err1)
    );

    act_pingpong_ram #(.WIDTH(32), .DEPTH(D), .ADDR_W(9), .RD_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data2), .o_rd_valid(rd_valid2),
        .i_swap(swap), .o_wr_bank(wr_bank2), .o_wr_cnt(wr_cnt2), .o_addr_err(addr_err2)
    );

    // Reference model state
    logic [31:0] m_mem [2][D];
    int          m_bank;
    int          m_cnt;
    bit          m_err;
    bit          e1_v, p_v, e2_v;
    logic [31:0] e1_d, p_d, e2_d;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit          wok, rok;
        logic [31:0] d;
        wok = int'(wr_addr) < D;
        rok = int'(rd_addr) < D;
        if (rst) begin
            m_bank = 0; m_cnt = 0; m_err = 0;
            e1_v = 0; e1_d = '0; p_v = 0; e2_v = 0; e2_d = '0;
        end else begin
            d = (rd_en && rok) ? m_mem[1 - m_bank][rd_addr] : 32'h0;
            e2_v = p_v;
            if (p_v) e2_d = p_d;
            p_v = rd_en;
            if (rd_en) p_d = d;
            e1_v = rd_en;
            if (rd_en) e1_d = d;
            if ((wr_en && !wok) || (rd_en && !rok)) m_err = 1;
            if (wr_en && wok) begin
                m_mem[m_bank][wr_addr] = wr_data;
                if (m_cnt < D) m_cnt++;
            end
            if (swap) begin
                m_cnt  = 0;
                m_bank = 1 - m_bank;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("valid_l1", 32'(rd_valid1), 32'(e1_v));
        chk("data_l1", rd_data1, e1_d);
        chk("valid_l2", 32'(rd_valid2), 32'(e2_v));
        chk("data_l2", rd_data2, e2_d);
        chk("wr_bank", 32'(wr_bank1), 32'(m_bank));
        chk("wr_bank_l2", 32'(wr_bank2), 32'(m_bank));
        chk("wr_cnt", 32'(wr_cnt1), 32'(m_cnt));
        chk("wr_cnt_l2", 32'(wr_cnt2), 32'(m_cnt));
        chk("addr_err", 32'(addr_err1), 32'(m_err));
        chk("addr_err_l2", 32'(addr_err2), 32'(m_err));
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input bit re, input int ra, input bit sw);
        wr_en   = we;
        wr_addr = 9'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = 9'(ra);
        swap    = sw;
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_data", rd_data1, 32'h0);
        chk("rst_valid", 32'(rd_valid2), 32'h0);
        rst = 1'b0;

        // Fill bank 0, saturate the counter, then swap
        for (int a = 0; a < D; a++) drive(1, a, 32'(a + 'h100), 0, 0, 0);
        chk("t1_cnt_full", 32'(wr_cnt1), 32'd424);
        drive(1, 3, 32'h103, 0, 0, 0);
        chk("t1_cnt_sat", 32'(wr_cnt1), 32'd424);
        drive(0, 0, 0, 0, 0, 1);
        chk("t1_bank", 32'(wr_bank1), 32'd1);
        chk("t1_cnt_swap", 32'(wr_cnt1), 32'd0);

        // Stream reads of bank 0 while filling bank 1 with random data
        for (int a = 0; a < D; a++) drive(1, a, $urandom, 1, a, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_last_l1", rd_data1, 32'h100 + 32'd423);
        chk("t2_last_l2", rd_data2, 32'h100 + 32'd423);

        // Write together with swap: write lands in old bank, counter ends at 0
        drive(1, 5, 32'hDEAD, 0, 0, 1);
        chk("t3_cnt", 32'(wr_cnt1), 32'd0);
        drive(0, 0, 0, 1, 5, 0);
        chk("t3_data_l1", rd_data1, 32'hDEAD);
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_data_l2", rd_data2, 32'hDEAD);

        // Read then swap on the next cycle
        drive(0, 0, 0, 1, 7, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Out-of-range write and read
        drive(1, 424, 32'hBAD, 0, 0, 0);
        chk("t5_err_rise", 32'(addr_err1), 32'd1);
        drive(0, 0, 0, 1, 511, 0);
        chk("t5_oob_valid", 32'(rd_valid1), 32'd1);
        chk("t5_oob_data", rd_data1, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_oob_data_l2", rd_data2, 32'h0);

        // Randomised traffic with occasional swaps and bad addresses
        for (int i = 0; i < 400; i++) begin
            int wa, ra;
            wa = ($urandom_range(15) == 0) ? D + int'($urandom_range(87)) : int'($urandom_range(D - 1));
            ra = ($urandom_range(15) == 0) ? D + int'($urandom_range(87)) : int'($urandom_range(D - 1));
            drive(1'($urandom_range(1)), wa, $urandom, 1'($urandom_range(1)), ra,
                  $urandom_range(19) == 0);
        end
        chk("rand_err_sticky", 32'(addr_err1), 32'(m_err));

        // Reset with two reads in flight; RAM must survive
        drive(0, 0, 0, 1, 10, 0);
        drive(0, 0, 0, 1, 11, 0);
        rst = 1'b1;
        drive(1, 12, 32'hFFFF, 0, 0, 0);
        rst = 1'b0;
        chk("t6_valid_l2", 32'(rd_valid2), 32'h0);
        chk("t6_err", 32'(addr_err1), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_no_late_valid", 32'(rd_valid2), 32'h0);
        drive(0, 0, 0, 1, 12, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 12, 0);
        drive(0, 0, 0, 1, 10, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
